// File: rtl/tcs_colour_emulator.sv
// Colour-sensor emulator: produces a 50% duty square wave whose half-period
// depends on the synchronised filter select {s2,s3} and the emulated object colour.
module tcs_colour_emulator #(
  parameter int MATCH_HALF    = 200,
  parameter int MISS_HALF     = 40,
  parameter int CLEAR_HALF    = 250,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       s2,
  input  logic       s3,
  input  logic [1:0] colour_sel,
  output logic       colour_freq,
  output logic [1:0] filter_id,
  output logic       period_done,
  output logic       busy
);

  // Values below 2 would make the terminal-count compare degenerate.
  localparam logic [15:0] MATCH_H  = (MATCH_HALF    < 2) ? 16'd2 : 16'(MATCH_HALF);
  localparam logic [15:0] MISS_H   = (MISS_HALF     < 2) ? 16'd2 : 16'(MISS_HALF);
  localparam logic [15:0] CLEAR_H  = (CLEAR_HALF    < 2) ? 16'd2 : 16'(CLEAR_HALF);
  localparam logic [15:0] SETTLE_C = (SETTLE_CYCLES < 2) ? 16'd2 : 16'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

  state_t      state;
  logic [1:0]  s_meta;
  logic [3:0]  cfg_q;
  logic [15:0] count;
  logic [15:0] half;
  logic [15:0] half_sel;
  logic [1:0]  filt_colour;
  logic        cfg_change;

  // Filter decode: 00 red, 01 blue, 10 clear, 11 green (colour codes 1 red, 2 green, 3 blue).
  always_comb begin
    filt_colour = 2'd0;
    case (filter_id)
      2'b00:   filt_colour = 2'd1;
      2'b01:   filt_colour = 2'd3;
      2'b11:   filt_colour = 2'd2;
      default: filt_colour = 2'd0;
    endcase
    if (filter_id == 2'b10)
      half_sel = CLEAR_H;
    else if (filt_colour == colour_sel)
      half_sel = MATCH_H;
    else
      half_sel = MISS_H;
  end

  // cfg_q holds last cycle's configuration so any change is seen for one cycle.
  assign cfg_change = (cfg_q != {filter_id, colour_sel});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta      <= 2'b00;
      filter_id   <= 2'b00;
      cfg_q       <= 4'd0;
      state       <= IDLE;
      count       <= 16'd0;
      half        <= 16'd2;
      colour_freq <= 1'b0;
      period_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      s_meta      <= {s2, s3};
      filter_id   <= s_meta;
      cfg_q       <= {filter_id, colour_sel};
      period_done <= 1'b0;
      if (!enable) begin
        state       <= IDLE;
        count       <= 16'd0;
        colour_freq <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state       <= SETTLE;
            count       <= 16'd0;
            colour_freq <= 1'b0;
            busy        <= 1'b1;
          end
          SETTLE: begin
            if (cfg_change) begin
              count <= 16'd0;
            end else if (count == SETTLE_C - 16'd1) begin
              state <= RUN;
              half  <= half_sel;
              count <= 16'd0;
              busy  <= 1'b0;
            end else begin
              count <= count + 16'd1;
            end
          end
          RUN: begin
            if (cfg_change) begin
              state       <= SETTLE;
              count       <= 16'd0;
              colour_freq <= 1'b0;
              busy        <= 1'b1;
            end else if (count == half - 16'd1) begin
              count       <= 16'd0;
              colour_freq <= ~colour_freq;
              period_done <= colour_freq;
            end else begin
              count <= count + 16'd1;
            end
          end
          default: begin
            state       <= IDLE;
            count       <= 16'd0;
            colour_freq <= 1'b0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
